scan_addr_gen: RTL and testbench
================================

# scan_addr_gen

Row-scan sequencer that drives the enable and 3-bit select inputs of the 3-to-8 structural decoder directly downstream. It steps the decoder through rows 0..NROWS-1. Each row gets a programmable blanking interval with the decoder disabled, then a programmable dwell interval with the decoder enabled. It supports single-frame and continuous scanning, and a graceful stop that never truncates a dwell.

## Interface
Parameters:
- NROWS, 8, number of rows scanned per frame; legal range 1..8.
- DWELL, 16, cycles en_out is high per row; must be ≥1.
- BLANK, 2, cycles en_out is low before each row's dwell; 0 is legal and means no blanking.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- stop  in  1  request termination at the next row boundary; sampled every cycle.
- continuous  in  1  1 = wrap to row 0 after the last row; sampled at each frame end.
- a_out  out  3  row select, connects to the decoder `a`.
- en_out  out  1  decoder enable, connects to the decoder `en`.
- row_start  out  1  one-cycle pulse on the first dwell cycle of every row.
- frame_done  out  1  one-cycle pulse after the last dwell cycle of row NROWS-1.
- busy  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, BLANK and DWELL. A down-counter sized to hold max(DWELL, BLANK) runs the timing, and a 3-bit row register holds the current row.
- All outputs are registered. On reset they take these values: a_out=0, en_out=0, row_start=0, frame_done=0, busy=0, state=IDLE, stop_pending=0.

IDLE:
- With start=1 and stop=0, set row=0 and go to BLANK. If BLANK=0, go straight to DWELL instead.
- With start and stop both high, stop wins: stay in IDLE.

BLANK:
- en_out=0 and a_out=row.
- After BLANK cycles, go to DWELL.

DWELL:
- en_out=1 and a_out=row.
- After DWELL cycles, take the row boundary described below.

Row boundary, evaluated on the last DWELL cycle:
- stop_pending=1: go to IDLE and clear stop_pending. frame_done is not pulsed.
- Else, row < NROWS-1: increment row and go to BLANK (or DWELL if BLANK=0).
- Else, at row NROWS-1: pulse frame_done. If continuous=1, set row=0 and continue. If continuous=0, go to IDLE.

Other rules:
- A stop seen in BLANK or DWELL sets stop_pending. It is ignored in IDLE.
- a_out changes only on transitions out of DWELL or IDLE. When BLANK≥1, en_out is therefore low whenever a_out changes, so the decoder never glitches between rows.
- With BLANK=0, a_out and en_out change on the same edge; the downstream decoder tolerates this.
- start while busy is ignored and is not queued.
- An rst_n assertion mid-scan forces every output to its reset value immediately. The first scan after reset needs a new start.
- With NROWS=1, row stays at 0 and frame_done pulses on every row boundary.

## Timing
- Take the edge that samples start as edge 0.
- busy rises after edge 0. BLANK occupies cycles 1..BLANK and DWELL occupies the next DWELL cycles.
- Per-row period is BLANK+DWELL cycles; a frame is NROWS×(BLANK+DWELL) cycles.
- row_start is high exactly on the first en_out=1 cycle of each row.
- frame_done is high for one cycle, the cycle after the last en_out=1 cycle of the frame.
  - In single-frame mode, busy=0 in that same cycle.
  - In continuous mode, frame_done coincides with the first BLANK cycle of row 0.
- The earliest restart after a single frame is start sampled on the edge that ends the frame_done cycle.
- stop latency: en_out falls on schedule at the end of the current dwell, and busy falls in that same cycle.

## Test plan
- Single frame, DWELL=4, BLANK=2, NROWS=8, start at edge 0:
  - en_out high for cycles 3-6 with a_out=0, then 9-12 with a_out=1, and so on, ending with cycles 45-48 with a_out=7.
  - frame_done and busy=0 at cycle 49.
  - Exactly 8 row_start pulses.
- Continuous mode, same parameters:
  - After the 48-cycle frame, a_out wraps 7→0 at cycle 49 with frame_done=1.
  - en_out is high again at cycles 51-54.
  - No gap cycles between frames.
- Stop during row 2 dwell (stop pulse at cycle 16):
  - Row 2 dwell completes through cycle 18, and busy=0 at cycle 19.
  - No frame_done, and a_out never reaches 3.
- Simultaneous start and stop in IDLE: busy stays 0. A start pulse while busy is ignored and the frame timing is unchanged.
- Reset mid-scan: rst_n low during cycle 20 (asynchronous, between edges) → en_out, busy and a_out are 0 at once. The design stays IDLE after release until the next start.
- BLANK=0, DWELL=1, NROWS=3: en_out is high for 3 consecutive cycles with a_out=0,1,2. frame_done follows on the next cycle.

Source files
------------

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: row-scan sequencer for a 3-to-8 decoder.
// Each row runs a blanking interval (decoder disabled), then a dwell
// interval (decoder enabled). Single-frame and continuous scanning are
// supported, plus a graceful stop taken at the next row boundary.
//
// Handshake: start is a level request sampled only while IDLE (ignored and
// not queued while busy); stop is sampled every cycle outside IDLE, latched,
// and acted on when the current dwell ends, so a dwell is never truncated.
module scan_addr_gen #(
    parameter int NROWS = 8,
    parameter int DWELL = 16,
    parameter int BLANK = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    output logic [2:0] a_out,
    output logic       en_out,
    output logic       row_start,
    output logic       frame_done,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    // The counter is loaded with interval-1 and runs down to zero.
    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [2:0]    LAST_ROW = 3'(NROWS - 1);

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic          row_start_d, frame_done_d;
    logic          begin_row;

    // Next-state logic: timing, row stepping and stop handling.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        stop_pend_d  = stop_pend_q;
        row_start_d  = 1'b0;
        frame_done_d = 1'b0;
        begin_row    = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    row_d     = 3'd0;
                    begin_row = 1'b1;
                end
            end
            S_BLANK: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DWELL;
                    cnt_d       = DWELL_LD;
                    row_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DWELL: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    // Row boundary: a stop seen during this row wins.
                    if (stop_pend_q || stop) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else if (row_q != LAST_ROW) begin
                        row_d     = row_q + 3'd1;
                        begin_row = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        if (continuous) begin
                            row_d     = 3'd0;
                            begin_row = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            stop_pend_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering a row: blank first unless blanking is zero-length.
        if (begin_row) begin
            if (BLANK > 0) begin
                state_d = S_BLANK;
                cnt_d   = BLANK_LD;
            end else begin
                state_d     = S_DWELL;
                cnt_d       = DWELL_LD;
                row_start_d = 1'b1;
            end
        end
    end

    // State, counter and registered outputs; outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= 3'd0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            a_out       <= 3'd0;
            en_out      <= 1'b0;
            row_start   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            a_out       <= row_d;
            en_out      <= (state_d == S_DWELL);
            row_start   <= row_start_d;
            frame_done  <= frame_done_d;
            busy        <= (state_d != S_IDLE);
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Bench for scan_addr_gen: two instances (8 rows / dwell 4 / blank 2 and
// 3 rows / dwell 1 / blank 0). Expected row, frame and busy-fall events are
// queued by the driver; a monitor pops and compares them as they appear.
module tb_scan_addr_gen;

    logic clk;
    logic rst_n;
    logic start_a, start_b, stop, continuous;

    logic [2:0] a_a, a_b;
    logic       en_a, en_b, rs_a, rs_b, fd_a, fd_b, busy_a, busy_b;
    logic [1:0] st_a, st_b;

    int n_cmp;
    int n_err;
    int cyc;
    int start_ref;
    logic sel_b;

    // Event record: {kind, row, cycle since start}; kind 0 row, 1 frame, 2 busy fall
    logic [14:0] exp_q[$];

    scan_addr_gen #(.NROWS(8), .DWELL(4), .BLANK(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop),
        .continuous(continuous), .a_out(a_a), .en_out(en_a),
        .row_start(rs_a), .frame_done(fd_a), .busy(busy_a), .state_dbg(st_a)
    );

    scan_addr_gen #(.NROWS(3), .DWELL(1), .BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop),
        .continuous(continuous), .a_out(a_b), .en_out(en_b),
        .row_start(rs_b), .frame_done(fd_b), .busy(busy_b), .state_dbg(st_b)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] ev(input logic [1:0] k, input logic [2:0] a, input int c);
        return {k, a, 10'(c)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: observe the selected instance and check against the queue
    logic [2:0] m_a;
    logic       m_en, m_rs, m_fd, m_busy;
    logic       prev_busy;
    assign m_a    = sel_b ? a_b : a_a;
    assign m_en   = sel_b ? en_b : en_a;
    assign m_rs   = sel_b ? rs_b : rs_a;
    assign m_fd   = sel_b ? fd_b : fd_a;
    assign m_busy = sel_b ? busy_b : busy_a;

    task automatic post_event(input logic [14:0] got);
        logic [14:0] want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL event: got kind=%0d row=%0d cyc=%0d expected kind=%0d row=%0d cyc=%0d",
                         got[14:13], got[12:10], got[9:0], want[14:13], want[12:10], want[9:0]);
            end
        end
    endtask

    initial prev_busy = 1'b0;
    always @(negedge clk) begin
        int rel;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            rel = cyc - start_ref;
            if (m_rs) begin
                post_event(ev(2'd0, m_a, rel));
                chk("row_start_en", int'(m_en), 1);
            end
            if (m_fd) post_event(ev(2'd1, 3'd0, rel));
            if (prev_busy && !m_busy) post_event(ev(2'd2, 3'd0, rel));
            prev_busy = m_busy;
        end
    end

    // Driver tasks
    task automatic do_start(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        start_ref = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic push_rows(input int first, input int period, input int nrows);
        for (int r = 0; r < nrows; r++) exp_q.push_back(ev(2'd0, 3'(r), first + r * period));
    endtask

    initial begin
        int en_cnt;
        int rel;
        int flag;

        n_cmp = 0; n_err = 0; cyc = 0; start_ref = 0; sel_b = 1'b0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stop = 1'b0; continuous = 1'b0;

        // Reset values
        #2;
        chk("rst_a_out", int'(a_a), 0);
        chk("rst_en_out", int'(en_a), 0);
        chk("rst_row_start", int'(rs_a), 0);
        chk("rst_frame_done", int'(fd_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_state", int'(st_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;

        // Start and stop together in IDLE: stop wins
        @(negedge clk);
        start_a = 1'b1; stop = 1'b1;
        @(negedge clk);
        start_a = 1'b0; stop = 1'b0;
        flag = 0;
        repeat (5) begin
            if (busy_a) flag = 1;
            @(negedge clk);
        end
        chk("start_stop_idle_busy", flag, 0);

        // Single frame, with an ignored start pulse while busy
        push_rows(3, 6, 8);
        exp_q.push_back(ev(2'd1, 3'd0, 49));
        exp_q.push_back(ev(2'd2, 3'd0, 49));
        do_start(1'b0);
        en_cnt = 0;
        rel = cyc - start_ref;
        while (rel <= 55) begin
            if (en_a) en_cnt++;
            if (rel == 49) chk("single_busy_49", int'(busy_a), 0);
            start_a = (rel == 10);
            @(negedge clk);
            rel = cyc - start_ref;
        end
        start_a = 1'b0;
        chk("single_en_cycles", en_cnt, 32);
        chk("single_queue_empty", exp_q.size(), 0);

        // Continuous: two frames back to back, then drop continuous
        continuous = 1'b1;
        push_rows(3, 6, 8);
        exp_q.push_back(ev(2'd1, 3'd0, 49));
        push_rows(51, 6, 8);
        exp_q.push_back(ev(2'd1, 3'd0, 97));
        exp_q.push_back(ev(2'd2, 3'd0, 97));
        do_start(1'b0);
        en_cnt = 0;
        rel = cyc - start_ref;
        while (rel <= 105) begin
            if (en_a) en_cnt++;
            if (rel == 49) begin
                chk("cont_wrap_a", int'(a_a), 0);
                chk("cont_wrap_fd", int'(fd_a), 1);
                chk("cont_wrap_busy", int'(busy_a), 1);
            end
            if (rel == 60) continuous = 1'b0;
            @(negedge clk);
            rel = cyc - start_ref;
        end
        chk("cont_en_cycles", en_cnt, 64);
        chk("cont_queue_empty", exp_q.size(), 0);

        // Stop during row 2 dwell
        push_rows(3, 6, 3);
        exp_q.push_back(ev(2'd2, 3'd0, 19));
        do_start(1'b0);
        en_cnt = 0; flag = 0;
        rel = cyc - start_ref;
        while (rel <= 30) begin
            if (en_a) en_cnt++;
            if (a_a == 3'd3) flag = 1;
            if (rel == 18) chk("stop_en_18", int'(en_a), 1);
            stop = (rel == 16);
            @(negedge clk);
            rel = cyc - start_ref;
        end
        stop = 1'b0;
        chk("stop_no_row3", flag, 0);
        chk("stop_en_cycles", en_cnt, 12);
        chk("stop_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-scan
        push_rows(3, 6, 3);
        do_start(1'b0);
        rel = cyc - start_ref;
        while (rel < 20) begin
            @(negedge clk);
            rel = cyc - start_ref;
        end
        chk("pre_reset_busy", int'(busy_a), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", int'(en_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_a", int'(a_a), 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        flag = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_a || en_a) flag = 1;
        end
        chk("post_rst_idle", flag, 0);
        chk("rst_queue_empty", exp_q.size(), 0);

        // BLANK=0, DWELL=1, NROWS=3 instance
        sel_b = 1'b1;
        push_rows(1, 1, 3);
        exp_q.push_back(ev(2'd1, 3'd0, 4));
        exp_q.push_back(ev(2'd2, 3'd0, 4));
        do_start(1'b1);
        en_cnt = 0;
        rel = cyc - start_ref;
        while (rel <= 10) begin
            if (en_b) en_cnt++;
            if (rel >= 1 && rel <= 3) chk("b_a_out", int'(a_b), rel - 1);
            @(negedge clk);
            rel = cyc - start_ref;
        end
        chk("b_en_cycles", en_cnt, 3);
        chk("b_queue_empty", exp_q.size(), 0);
        chk("a_stayed_idle", int'(busy_a), 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
